// File: rtl/sci_alu_sweep_collector.sv
// Sweep sequencer for the scientific ALU: issues every opcode against one latched
// operand pair, waits a settle time per opcode and records result/flags per opcode.
module sci_alu_sweep_collector #(
  parameter int OP_COUNT = 16,
  parameter int SETTLE   = 4,
  parameter int DW       = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_opcode,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_excep,
  input  logic          alu_err,
  output logic          busy,
  output logic          done,
  input  logic [3:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_excep,
  output logic          rd_err,
  output logic          rd_valid,
  output logic [4:0]    excep_count,
  output logic [4:0]    err_count
);

  localparam logic [3:0] LAST_OP   = 4'(OP_COUNT - 1);
  localparam logic [3:0] WAIT_LOAD = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   alu_a_q;
  logic [DW-1:0]   alu_b_q;
  logic [3:0]      op_q;
  logic [3:0]      wait_q;
  logic            busy_q;
  logic            done_q;
  logic [15:0]     valid_q;
  logic [4:0]      excnt_q;
  logic [4:0]      errcnt_q;
  logic [4:0]      excnt_d;
  logic [4:0]      errcnt_d;

  // Buffer storage is gated by valid_q, so it carries no reset.
  logic [DW-1:0]   data_q [16];
  logic [15:0]     ex_q;
  logic [15:0]     er_q;

  // Tally candidates for the capture cycle.
  always_comb begin
    excnt_d  = excnt_q + {4'd0, alu_excep};
    errcnt_d = errcnt_q + {4'd0, alu_err};
  end

  // Sweep FSM; busy/done are registered from the state and so trail it by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      op_q     <= 4'd0;
      wait_q   <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 16'd0;
      excnt_q  <= 5'd0;
      errcnt_q <= 5'd0;
    end else begin
      busy_q <= (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_CAPTURE);
      done_q <= (state_q == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            alu_a_q  <= a_in;
            alu_b_q  <= b_in;
            op_q     <= 4'd0;
            valid_q  <= 16'd0;
            excnt_q  <= 5'd0;
            errcnt_q <= 5'd0;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_q  <= WAIT_LOAD;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == 4'd0) begin
            state_q <= ST_CAPTURE;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        ST_CAPTURE: begin
          valid_q[op_q] <= 1'b1;
          excnt_q       <= excnt_d;
          errcnt_q      <= errcnt_d;
          if (op_q == LAST_OP) begin
            state_q <= ST_DONE;
          end else begin
            op_q    <= op_q + 4'd1;
            state_q <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Result buffer write on the capture cycle.
  always_ff @(posedge clk) begin
    if (state_q == ST_CAPTURE) begin
      data_q[op_q] <= alu_result;
      ex_q[op_q]   <= alu_excep;
      er_q[op_q]   <= alu_err;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_opcode  = op_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign excep_count = excnt_q;
  assign err_count   = errcnt_q;

  assign rd_data  = data_q[rd_addr];
  assign rd_excep = ex_q[rd_addr];
  assign rd_err   = er_q[rd_addr];
  assign rd_valid = valid_q[rd_addr];

endmodule
